// File: rtl/byte_decode_ctrl.sv
// byte_decode_ctrl: ByteDecode_d sequencer for Kyber decryption.
// Pulls bytes into a small LSB-first bit window and emits N_COEFF d-bit
// coefficients over valid/ready.
// Optional feature macro: BYTE_DECODE_MODQ_EN (reduce d==12 coefficients mod Q).
//
// Handshake rule: a transfer happens on a rising clk edge where valid & ready
// are both high. in_ready and out_valid are decoded from registers only, and
// never depend on in_valid/out_ready. They are never high together. out_valid
// stays high, with out_coeff/out_idx held stable, until out_ready is seen.
module byte_decode_ctrl #(
  parameter int N_COEFF = 256,
  parameter int MAX_D   = 12,
  parameter int Q       = 3329
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       d_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             out_valid,
  output logic [MAX_D-1:0] out_coeff,
  output logic [7:0]       out_idx,
  input  logic             out_ready,
  output logic [1:0]       dbg_state
);

  localparam int AW  = MAX_D + 8;
  localparam int CW  = $clog2(AW);
  localparam int BLW = $clog2(32 * MAX_D + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       d_q;
  logic [AW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic [BLW-1:0]   bytes_left_q;
  logic [7:0]       coeff_cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [CW-1:0]    d_w;
  logic [AW-1:0]    acc_ins_d;
  logic [AW-1:0]    acc_shr_d;
  logic [MAX_D-1:0] coeff_mask;
  logic [MAX_D-1:0] coeff_raw;
  logic             d_in_legal;

  // Only these widths occur in ByteDecode for Kyber.
  always_comb begin
    case (d_in)
      4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12: d_in_legal = 1'b1;
      default:                               d_in_legal = 1'b0;
    endcase
  end

  assign d_w       = CW'(d_q);
  assign in_ready  = (state_q == S_RUN) && (cnt_q < d_w) && (bytes_left_q != '0);
  assign out_valid = (state_q == S_RUN) && (cnt_q >= d_w);

  // Bits above cnt are zero, so OR-ing the new byte in never collides.
  assign acc_ins_d = acc_q | (AW'(in_byte) << cnt_q);
  assign acc_shr_d = acc_q >> d_q;

  // Low d bits of the window form the current coefficient.
  assign coeff_mask = ~({MAX_D{1'b1}} << d_q);
  assign coeff_raw  = acc_q[MAX_D-1:0] & coeff_mask;

`ifdef BYTE_DECODE_MODQ_EN
  localparam logic [MAX_D-1:0] Q_C = MAX_D'(Q);
  // Single conditional subtract folds 12-bit values into [0, Q).
  always_comb begin
    out_coeff = coeff_raw;
    if ((d_q == 4'd12) && (coeff_raw >= Q_C)) out_coeff = coeff_raw - Q_C;
  end
`else
  assign out_coeff = coeff_raw;
`endif

  assign out_idx   = coeff_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  // Control FSM with window/counter datapath and registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      d_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      bytes_left_q <= '0;
      coeff_cnt_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (d_in_legal) begin
              d_q          <= d_in;
              acc_q        <= '0;
              cnt_q        <= '0;
              bytes_left_q <= BLW'({d_in, 5'b0});
              coeff_cnt_q  <= '0;
              busy_q       <= 1'b1;
              state_q      <= S_RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (in_ready && in_valid) begin
            acc_q        <= acc_ins_d;
            cnt_q        <= cnt_q + CW'(8);
            bytes_left_q <= bytes_left_q - BLW'(1);
          end else if (out_valid && out_ready) begin
            acc_q       <= acc_shr_d;
            cnt_q       <= cnt_q - d_w;
            coeff_cnt_q <= coeff_cnt_q + 8'd1;
            if (coeff_cnt_q == 8'(N_COEFF - 1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_decode_ctrl.sv
// Bench for byte_decode_ctrl: bit-level ByteDecode reference model, random
// valid/ready pressure, abort by reset, illegal widths.
module tb_byte_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  d_in;
  logic        busy, done, err;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] out_coeff;
  logic [7:0]  out_idx;
  logic        out_ready;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  stim_bytes [384];
  logic [11:0] obs_coeff  [256];

  byte_decode_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .d_in(d_in),
    .busy(busy), .done(done), .err(err),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .out_valid(out_valid), .out_coeff(out_coeff), .out_idx(out_idx),
    .out_ready(out_ready), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 384; i++) stim_bytes[i] = 8'($urandom_range(0, 255));
  endtask

  // Reference ByteDecode_d: coefficient i takes stream bits i*d .. i*d+d-1,
  // stream bit k being bit (k%8) of byte k/8.
  task automatic build_expected(input int d, output logic [11:0] exp_q[$]);
    exp_q = {};
    for (int i = 0; i < 256; i++) begin
      int c = 0;
      for (int j = 0; j < d; j++) begin
        int k = i * d + j;
        c += ((stim_bytes[k / 8] >> (k % 8)) & 1) << j;
      end
`ifdef BYTE_DECODE_MODQ_EN
      if (d == 12 && c >= 3329) c -= 3329;
`endif
      exp_q.push_back(12'(c));
    end
  endtask

  // Driver + scoreboard for one run. mode 0: full rate; mode 1: random
  // valid/ready plus junk start/d_in. abort_at>0: reset once that many
  // coefficients have been taken.
  task automatic run_decode(input int d, input int mode, input int abort_at);
    logic [11:0] exp_q[$];
    logic [11:0] held_c;
    logic [7:0]  held_i;
    logic [11:0] e;
    int nb = 0, nc = 0, cyc = 0, avail;
    bit stalled = 0, aborted = 0, hs_in, hs_out;

    build_expected(d, exp_q);
    start = 1'b1; d_in = 4'(d);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);

    while (nc < 256 && cyc < 20000 && !aborted) begin
      avail = nb * 8 - nc * d;
      chk("out_valid", out_valid, avail >= d);
      chk("in_ready", in_ready, (avail < d) && (nb < 32 * d));
      chk("busy_run", busy, 1);
      if (stalled) begin
        chk("stall_coeff", out_coeff, held_c);
        chk("stall_idx", out_idx, held_i);
      end
      in_valid  = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_byte   = (nb < 32 * d) ? stim_bytes[nb] : 8'($urandom_range(0, 255));
      out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      start     = (mode == 0) ? 1'b0 : ($urandom_range(0, 7) == 0);
      d_in      = (mode == 0) ? 4'(d) : 4'($urandom_range(0, 15));
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      if (hs_out) begin
        e = exp_q.pop_front();
        chk("coeff", out_coeff, e);
        chk("idx", out_idx, nc);
        obs_coeff[nc] = out_coeff;
        nc++;
      end
      stalled = out_valid && !out_ready;
      held_c  = out_coeff;
      held_i  = out_idx;
      if (hs_in) nb++;
      if (abort_at > 0 && nc == abort_at) begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        aborted = 1;
      end
      tick();
      cyc++;
    end

    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    if (aborted) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_coeff", out_coeff, 0);
      chk("rst_out_idx", out_idx, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_busy", busy, 0);
    end else begin
      chk("run_completed", nc, 256);
      chk("bytes_used", nb, 32 * d);
      chk("done_pulse", done, 1);
      chk("busy_at_done", busy, 0);
      chk("no_ready_at_done", in_ready, 0);
      chk("no_valid_at_done", out_valid, 0);
      tick();
      chk("done_cleared", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    int pat [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int bad [10] = '{0, 2, 3, 6, 7, 8, 9, 13, 14, 15};
    int legal [6] = '{1, 4, 5, 10, 11, 12};

    rst = 1'b1; start = 1'b0; d_in = 4'd0; in_valid = 1'b0;
    in_byte = 8'd0; out_ready = 1'b0;
    tick(); tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    rst = 1'b0;
    tick();

    // d=12, bytes 01 23 45 67 ...
    for (int i = 0; i < 384; i++) stim_bytes[i] = 8'(i * 8'h22 + 1);
    run_decode(12, 0, 0);
    chk("d12_coeff0", obs_coeff[0], 12'h301);
    chk("d12_coeff1", obs_coeff[1], 12'h452);

    // d=1, all 0xA5
    for (int i = 0; i < 384; i++) stim_bytes[i] = 8'hA5;
    run_decode(1, 0, 0);
    for (int k = 0; k < 8; k++) chk("d1_pattern", obs_coeff[k], pat[k]);
    chk("d1_last", obs_coeff[255], 1);

    // d=10 with random back-pressure
    fill_random();
    run_decode(10, 1, 0);

    // Illegal widths
    for (int i = 0; i < 10; i++) begin
      start = 1'b1; d_in = 4'(bad[i]);
      tick();
      start = 1'b0;
      chk("illegal_err", err, 1);
      chk("illegal_busy", busy, 0);
      chk("illegal_in_ready", in_ready, 0);
      tick();
      chk("illegal_err_clear", err, 0);
      chk("illegal_still_idle", busy, 0);
    end

    // Reset after 100 coefficients, then a fresh d=4 run
    fill_random();
    run_decode(legal[$urandom_range(0, 5)], 1, 100);
    fill_random();
    run_decode(4, 1, 0);

    // Value near/above Q with d=12
    fill_random();
    stim_bytes[0] = 8'hFF; stim_bytes[1] = 8'h0F;
    run_decode(12, 1, 0);
`ifdef BYTE_DECODE_MODQ_EN
    chk("d12_modq", obs_coeff[0], 12'h2FE);
`else
    chk("d12_raw", obs_coeff[0], 12'hFFF);
`endif

    // Remaining widths under random pressure
    fill_random();
    run_decode(5, 1, 0);
    fill_random();
    run_decode(11, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
